// File: rtl/led_fade_pwm_ctrl.sv
// led_fade_pwm_ctrl
//   Avalon-MM slave that drives NUM_LEDS LED outputs from one shared,
//   free-running PWM counter. Each channel either fades out linearly after a
//   trigger (MODE=0) or follows its own static duty register (MODE=1).
//
//   Register map (word addresses):
//     0      CTRL      rw  bit0 EN, bit1 MODE (0 fade, 1 static)
//     1      TRIGGER   wo  bit i loads fade_level[i] with full scale; reads 0
//     2      FADE_DIV  rw  clocks per fade tick minus 1 (32 bits)
//     3      STATUS    ro  bit i = (fade_level[i] != 0)
//     4+i    DUTY[i]   rw  low PWM_BITS bits
//     others           read 0, writes ignored
//
//   Ports:
//     clk_clk                 system clock
//     rst_reset               asynchronous active-high reset
//     avalon_slave_address    word address
//     avalon_slave_write      write strobe
//     avalon_slave_writedata  write data
//     avalon_slave_read       read strobe
//     avalon_slave_readdata   registered read data
//     leds                    registered LED drive
//
//   Bus handshake: write and read are single-cycle strobes that are always
//   accepted (there is no waitrequest). Read data appears on the clock after
//   the read strobe is sampled and holds until the next read. A write and a
//   read in the same cycle return the register value from before the write.
module led_fade_pwm_ctrl #(
  parameter int          NUM_LEDS         = 26,
  parameter int          PWM_BITS         = 8,
  parameter logic [31:0] FADE_DIV_DEFAULT = 32'd65535,
  parameter int          ADDR_W           = 5
) (
  input  logic                clk_clk,
  input  logic                rst_reset,
  input  logic [ADDR_W-1:0]   avalon_slave_address,
  input  logic                avalon_slave_write,
  input  logic [31:0]         avalon_slave_writedata,
  input  logic                avalon_slave_read,
  output logic [31:0]         avalon_slave_readdata,
  output logic [NUM_LEDS-1:0] leds
);

  logic                en;
  logic                mode;
  logic [31:0]         fade_div;
  logic [31:0]         presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty       [NUM_LEDS];
  logic [PWM_BITS-1:0] fade_level [NUM_LEDS];

  logic                wr_ctrl;
  logic                wr_trig;
  logic                wr_fdiv;
  logic                duty_hit;
  logic [ADDR_W-1:0]   duty_idx;
  logic                tick;
  logic [NUM_LEDS-1:0] status;
  logic [NUM_LEDS-1:0] led_next;
  logic [31:0]         rd_val;

  assign wr_ctrl  = avalon_slave_write && (avalon_slave_address == ADDR_W'(0));
  assign wr_trig  = avalon_slave_write && (avalon_slave_address == ADDR_W'(1));
  assign wr_fdiv  = avalon_slave_write && (avalon_slave_address == ADDR_W'(2));
  assign duty_idx = avalon_slave_address - ADDR_W'(4);
  // One extra bit so 4+NUM_LEDS == 2^ADDR_W does not wrap to zero.
  assign duty_hit = ({1'b0, avalon_slave_address} >= (ADDR_W+1)'(4)) &&
                    ({1'b0, avalon_slave_address} <  (ADDR_W+1)'(4 + NUM_LEDS));

  // A FADE_DIV write reloads the prescaler instead of letting it tick.
  assign tick = (presc == 32'd0) && !wr_fdiv;

  always_comb begin
    status   = '0;
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      status[i]   = (fade_level[i] != '0);
      led_next[i] = en && ((mode ? duty[i] : fade_level[i]) > pwm_cnt);
    end
  end

  always_comb begin
    rd_val = '0;
    case (avalon_slave_address)
      ADDR_W'(0): rd_val[1:0] = {mode, en};
      ADDR_W'(2): rd_val = fade_div;
      ADDR_W'(3): rd_val[NUM_LEDS-1:0] = status;
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (duty_hit && (duty_idx == ADDR_W'(i))) rd_val[PWM_BITS-1:0] = duty[i];
        end
      end
    endcase
  end

  // Control registers, PWM counter and prescaler.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      en       <= 1'b1;
      mode     <= 1'b0;
      fade_div <= FADE_DIV_DEFAULT;
      presc    <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wr_ctrl) begin
        en   <= avalon_slave_writedata[0];
        mode <= avalon_slave_writedata[1];
      end
      if (wr_fdiv) begin
        fade_div <= avalon_slave_writedata;
        presc    <= avalon_slave_writedata;
      end else if (tick) begin
        presc <= fade_div;
      end else begin
        presc <= presc - 32'd1;
      end
    end
  end

  // Per-channel duty and fade state; trigger beats a coincident tick.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty[i]       <= '0;
        fade_level[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (avalon_slave_write && duty_hit && (duty_idx == ADDR_W'(i)))
          duty[i] <= avalon_slave_writedata[PWM_BITS-1:0];
        if (wr_trig && avalon_slave_writedata[i])
          fade_level[i] <= '1;
        else if (tick && (fade_level[i] != '0))
          fade_level[i] <= fade_level[i] - PWM_BITS'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      leds                  <= '0;
      avalon_slave_readdata <= '0;
    end else begin
      leds <= led_next;
      if (avalon_slave_read) avalon_slave_readdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm_ctrl.sv
module tb_led_fade_pwm_ctrl;
  localparam int NL     = 4;
  localparam int PB     = 4;
  localparam int AW     = 5;
  localparam int FULL   = 15;
  localparam int PERIOD = 16;

  // ---------------- clock / reset ----------------
  logic          clk_clk = 1'b0;
  logic          rst_reset;
  logic [AW-1:0] addr;
  logic          wr;
  logic          rd;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [NL-1:0] leds;

  always #5 clk_clk = ~clk_clk;

  led_fade_pwm_ctrl #(
    .NUM_LEDS(NL), .PWM_BITS(PB), .FADE_DIV_DEFAULT(32'd3), .ADDR_W(AW)
  ) dut (
    .clk_clk(clk_clk),
    .rst_reset(rst_reset),
    .avalon_slave_address(addr),
    .avalon_slave_write(wr),
    .avalon_slave_writedata(wdata),
    .avalon_slave_read(rd),
    .avalon_slave_readdata(rdata),
    .leds(leds)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: pwm phase is the cycle count mod 16, and the prescaler
  // is represented by the absolute cycle number of the next tick.
  longint      m_cyc;
  longint      m_next_tick;
  longint      m_fade_div;
  int          m_ctrl;
  int          m_duty[NL];
  int          m_fl[NL];
  int          m_pwm;
  logic [NL-1:0] m_leds;

  task automatic model_reset();
    m_cyc = 0; m_next_tick = 0; m_fade_div = 3; m_ctrl = 1; m_pwm = 0; m_leds = '0;
    for (int i = 0; i < NL; i++) begin m_duty[i] = 0; m_fl[i] = 0; end
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] v;
    v = 0;
    if (a == 0) v = 32'(m_ctrl);
    else if (a == 2) v = 32'(m_fade_div);
    else if (a == 3) begin
      for (int i = 0; i < NL; i++) if (m_fl[i] != 0) v[i] = 1'b1;
    end else if (a >= 4 && a < 4 + NL) v = 32'(m_duty[a-4]);
    return v;
  endfunction

  task automatic model_step(input bit w, input bit r, input int a, input logic [31:0] d);
    bit tick;
    int lvl;
    for (int i = 0; i < NL; i++) begin
      lvl = m_ctrl[1] ? m_duty[i] : m_fl[i];
      m_leds[i] = m_ctrl[0] && (lvl > m_pwm);
    end
    if (r) exp_q.push_back(m_read(a));
    tick = (m_cyc == m_next_tick) && !(w && a == 2);
    for (int i = 0; i < NL; i++) begin
      if (w && a == 1 && d[i]) m_fl[i] = FULL;
      else if (tick && m_fl[i] > 0) m_fl[i] = m_fl[i] - 1;
    end
    if (w && a == 2) m_next_tick = m_cyc + 1 + longint'(d);
    else if (tick) m_next_tick = m_cyc + 1 + m_fade_div;
    if (w) begin
      if (a == 0) m_ctrl = int'(d & 32'd3);
      else if (a == 2) m_fade_div = longint'(d);
      else if (a >= 4 && a < 4 + NL) m_duty[a-4] = int'(d & 32'd15);
    end
    m_pwm = (m_pwm + 1) % PERIOD;
    m_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  // Every task starts and ends just after a falling edge.
  task automatic bus_cycle(input bit w, input bit r, input int a, input logic [31:0] d);
    logic [31:0] e;
    wr = w; rd = r; addr = AW'(a); wdata = d;
    @(posedge clk_clk);
    model_step(w, r, a, d);
    #1;
    check_val("leds", 32'(leds), 32'(m_leds));
    if (r) begin
      e = exp_q.pop_front();
      check_val("rdata", rdata, e);
    end
    @(negedge clk_clk);
    wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) bus_cycle(1'b0, 1'b0, 0, 32'd0);
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input int a, output logic [31:0] v);
    bus_cycle(1'b0, 1'b1, a, 32'd0);
    v = rdata;
  endtask

  task automatic count_led(input int idx, input int n, output int c);
    c = 0;
    repeat (n) begin
      idle(1);
      c += int'(leds[idx]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int          c;
    int          first_zero;
    int          found;
    logic [NL-1:0] acc;

    rst_reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk_clk);
    check_val("reset_leds", 32'(leds), 32'd0);
    check_val("reset_rdata", rdata, 32'd0);
    rst_reset = 1'b0;
    model_reset();

    // Reset values
    rd_reg(0, v); check_val("rst_ctrl", v, 32'h1);
    rd_reg(2, v); check_val("rst_fdiv", v, 32'd3);
    rd_reg(3, v); check_val("rst_status", v, 32'd0);
    rd_reg(7, v); check_val("rst_duty3", v, 32'd0);
    rd_reg(20, v); check_val("unmapped_rd", v, 32'd0);

    // Trigger and fade (slow ticks while measuring duty)
    wr_reg(2, 32'd100);
    wr_reg(1, 32'hFFFF_FFF5);           // bits >= NL must be ignored
    rd_reg(3, v); check_val("trig_status", v, 32'h5);
    rd_reg(1, v); check_val("trig_readback", v, 32'd0);
    count_led(0, 16, c); check_val("fade_duty0", 32'(c), 32'd15);
    count_led(2, 16, c); check_val("fade_duty2", 32'(c), 32'd15);
    count_led(1, 16, c); check_val("fade_duty1", 32'(c), 32'd0);
    count_led(3, 16, c); check_val("fade_duty3", 32'(c), 32'd0);
    // Prescaler reload 3 at the write: 15 ticks at +4..+60, zero seen by
    // the read 61 clocks after the write.
    wr_reg(2, 32'd3);
    first_zero = -1;
    for (int j = 1; j <= 200 && first_zero < 0; j++) begin
      rd_reg(3, v);
      if (v == 32'd0) first_zero = j;
    end
    check_val("fade_zero_time", 32'(first_zero), 32'd61);

    // Static mode
    wr_reg(0, 32'h3);
    wr_reg(5, 32'd4);
    count_led(1, 16, c); check_val("static_duty4", 32'(c), 32'd4);
    rd_reg(5, v); check_val("duty1_rd", v, 32'd4);
    wr_reg(5, 32'd0);
    count_led(1, 16, c); check_val("static_duty0", 32'(c), 32'd0);
    wr_reg(3, 32'hF);                    // STATUS is read-only
    rd_reg(3, v); check_val("status_ro", v, 32'd0);

    // Enable gating
    wr_reg(4, 32'd15);
    wr_reg(1, 32'h1);
    wr_reg(0, 32'h2);
    acc = '0;
    repeat (20) begin idle(1); acc |= leds; end
    check_val("gate_leds", 32'(acc), 32'd0);
    rd_reg(3, v); check_val("gate_status_live", v, 32'h1);
    found = 0;
    for (int j = 0; j < 120 && found == 0; j++) begin
      rd_reg(3, v);
      if (v == 32'd0) found = 1;
    end
    check_val("gate_decay", 32'(found), 32'd1);

    // Trigger on the same clock as a tick, with fade_level[0] = 7
    wr_reg(0, 32'h1);
    wr_reg(1, 32'h1);
    found = 0;
    for (int j = 0; j < 200 && found == 0; j++) begin
      if (m_fl[0] == 7 && m_cyc == m_next_tick) found = 1;
      else idle(1);
    end
    check_val("collide_setup", 32'(found), 32'd1);
    wr_reg(1, 32'h1);
    wr_reg(2, 32'd100);
    count_led(0, 16, c); check_val("collide_level", 32'(c), 32'd15);

    // FADE_DIV = 0: a tick every clock
    wr_reg(2, 32'd0);
    wr_reg(1, 32'h8);
    first_zero = -1;
    for (int j = 1; j <= 100 && first_zero < 0; j++) begin
      rd_reg(3, v);
      if (v[3] == 1'b0) first_zero = j;
    end
    check_val("div0_zero_time", 32'(first_zero), 32'd16);

    // Reset in the middle of a fade
    wr_reg(2, 32'd100);
    wr_reg(1, 32'hF);
    idle(3);
    rd_reg(0, v);
    #2 rst_reset = 1'b1;
    #1;
    check_val("midrst_leds", 32'(leds), 32'd0);
    check_val("midrst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk_clk);
    rst_reset = 1'b0;
    model_reset();
    rd_reg(3, v); check_val("midrst_status", v, 32'd0);
    rd_reg(2, v); check_val("midrst_fdiv", v, 32'd3);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      int a;
      bit w;
      bit r;
      logic [31:0] d;
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (a == 2) d = 32'($urandom_range(0, 7));
      bus_cycle(w, r, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
